// File: rtl/four_bit_demux_buf_if.sv
// Bus bundle for the buffered 1-to-2 demux: producer side plus both consumer channels.
// The master modport is the producer/consumer environment; the slave modport is the demux itself.
interface four_bit_demux_buf_if #(
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_data;
  logic          in_sel;
  logic          a_valid;
  logic          a_ready;
  logic [3:0]    a_data;
  logic          b_valid;
  logic          b_ready;
  logic [3:0]    b_data;
  logic [CW-1:0] a_count;
  logic [CW-1:0] b_count;

  modport master (
    output in_valid, in_data, in_sel, a_ready, b_ready,
    input  in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );

  modport slave (
    input  in_valid, in_data, in_sel, a_ready, b_ready,
    output in_ready, a_valid, a_data, b_valid, b_data, a_count, b_count
  );
endinterface

// File: rtl/four_bit_demux_buf.sv
// Steers 4-bit words into one of two independent FIFOs (A for sel=0, B for sel=1),
// each draining through its own valid/ready handshake.
module four_bit_demux_buf #(
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH) + 1,
  localparam int PW    = $clog2(DEPTH)
) (
  input logic                    clk,
  input logic                    rst_n,
  four_bit_demux_buf_if.slave    bus
);

  logic [3:0]    mem_q    [2][DEPTH];
  logic [PW-1:0] wr_ptr_q [2];
  logic [PW-1:0] wr_ptr_d [2];
  logic [PW-1:0] rd_ptr_q [2];
  logic [PW-1:0] rd_ptr_d [2];
  logic [CW-1:0] cnt_q    [2];
  logic [CW-1:0] cnt_d    [2];

  logic [1:0] full;
  logic [1:0] valid;
  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] ready_in;
  logic       in_ready_w;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = (cnt_q[c] == CW'(DEPTH));
      valid[c] = (cnt_q[c] != '0);
    end
  end

  // Acceptance looks only at the selected channel's pre-edge occupancy, so a
  // same-cycle pop on a full channel never opens the input.
  assign in_ready_w = bus.in_sel ? ~full[1] : ~full[0];
  assign ready_in   = {bus.b_ready, bus.a_ready};

  assign push[0] = bus.in_valid & in_ready_w & ~bus.in_sel;
  assign push[1] = bus.in_valid & in_ready_w &  bus.in_sel;
  assign pop     = valid & ready_in;

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      wr_ptr_d[c] = wr_ptr_q[c];
      rd_ptr_d[c] = rd_ptr_q[c];
      cnt_d[c]    = cnt_q[c];
      if (push[c]) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      if (pop[c])  rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      case ({push[c], pop[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int e = 0; e < DEPTH; e++) mem_q[c][e] <= '0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= wr_ptr_d[c];
        rd_ptr_q[c] <= rd_ptr_d[c];
        cnt_q[c]    <= cnt_d[c];
        if (push[c]) mem_q[c][wr_ptr_q[c]] <= bus.in_data;
      end
    end
  end

  assign bus.in_ready = in_ready_w;
  assign bus.a_valid  = valid[0];
  assign bus.b_valid  = valid[1];
  assign bus.a_data   = mem_q[0][rd_ptr_q[0]];
  assign bus.b_data   = mem_q[1][rd_ptr_q[1]];
  assign bus.a_count  = cnt_q[0];
  assign bus.b_count  = cnt_q[1];

endmodule

// File: tb/tb_four_bit_demux_buf.sv
// Directed bench for four_bit_demux_buf: stimulus queues expected words per channel,
// a negedge monitor pops and compares whenever a channel hands a word over.
module tb_four_bit_demux_buf;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [3:0] qa[$];
  logic [3:0] qb[$];

  four_bit_demux_buf_if #(.DEPTH(2)) bus ();

  four_bit_demux_buf #(.DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endfunction

  // Monitor: a word is taken at the next rising edge whenever valid & ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.a_valid && bus.a_ready) begin
        if (qa.size() == 0) check("a_unexpected_word", int'(bus.a_data), 16);
        else                check("a_data_order", int'(bus.a_data), int'(qa.pop_front()));
      end
      if (bus.b_valid && bus.b_ready) begin
        if (qb.size() == 0) check("b_unexpected_word", int'(bus.b_data), 16);
        else                check("b_data_order", int'(bus.b_data), int'(qb.pop_front()));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] d, input logic s, input logic exp_acc);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_sel   = s;
    @(negedge clk);
    check("in_ready_on_push", int'(bus.in_ready), int'(exp_acc));
    if (exp_acc) begin
      if (s) qb.push_back(d);
      else   qa.push_back(d);
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !bus.a_valid && !bus.b_valid) break;
    end
    check("drain_qa_empty", qa.size(), 0);
    check("drain_qb_empty", qb.size(), 0);
    step();
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    check("drain_a_count", int'(bus.a_count), 0);
    check("drain_b_count", int'(bus.b_count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'h0;
    bus.in_sel   = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;

    // Reset state
    #12;
    check("rst_a_valid", int'(bus.a_valid), 0);
    check("rst_b_valid", int'(bus.b_valid), 0);
    check("rst_a_count", int'(bus.a_count), 0);
    check("rst_b_count", int'(bus.b_count), 0);
    check("rst_a_data",  int'(bus.a_data),  0);
    check("rst_b_data",  int'(bus.b_data),  0);
    check("rst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Routing
    push(4'h5, 1'b0, 1'b1);
    push(4'hA, 1'b1, 1'b1);
    @(negedge clk);
    check("route_a_data",  int'(bus.a_data),  5);
    check("route_b_data",  int'(bus.b_data),  10);
    check("route_a_count", int'(bus.a_count), 1);
    check("route_b_count", int'(bus.b_count), 1);
    step();
    drain();

    // Fill and stall
    push(4'h1, 1'b0, 1'b1);
    push(4'h2, 1'b0, 1'b1);
    check("fill_a_count", int'(bus.a_count), 2);
    bus.in_sel = 1'b0;
    #1 check("fill_ready_sel0", int'(bus.in_ready), 0);
    bus.in_sel = 1'b1;
    #1 check("fill_ready_sel1", int'(bus.in_ready), 1);
    push(4'h3, 1'b1, 1'b1);
    check("fill_b_count", int'(bus.b_count), 1);

    // Full with pop: push refused while A pops 0x1, then accepted next cycle
    bus.a_ready = 1'b1;
    push(4'h3, 1'b0, 1'b0);
    check("fullpop_a_count", int'(bus.a_count), 1);
    push(4'h3, 1'b0, 1'b1);
    check("fullpop_a_count2", int'(bus.a_count), 1);
    drain();

    // Wrap and streaming through A
    bus.a_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_sel   = 1'b0;
      bus.in_data  = 4'(i);
      @(negedge clk);
      check("stream_a_count", int'(bus.a_count), (i == 0) ? 0 : 1);
      check("stream_in_ready", int'(bus.in_ready), 1);
      qa.push_back(4'(i));
      step();
    end
    bus.in_valid = 1'b0;
    check("stream_end_count", int'(bus.a_count), 1);
    drain();

    // Reset mid-operation
    push(4'h7, 1'b0, 1'b1);
    push(4'h9, 1'b1, 1'b1);
    push(4'hE, 1'b1, 1'b1);
    check("pre_rst_b_count", int'(bus.b_count), 2);
    #1;
    rst_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    check("midrst_a_valid", int'(bus.a_valid), 0);
    check("midrst_b_valid", int'(bus.b_valid), 0);
    check("midrst_a_count", int'(bus.a_count), 0);
    check("midrst_b_count", int'(bus.b_count), 0);
    check("midrst_a_data",  int'(bus.a_data),  0);
    check("midrst_in_ready", int'(bus.in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    push(4'hC, 1'b1, 1'b1);
    @(negedge clk);
    check("post_rst_b_data",  int'(bus.b_data),  12);
    check("post_rst_b_count", int'(bus.b_count), 1);
    check("post_rst_a_count", int'(bus.a_count), 0);
    step();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
